// File: rtl/ro_pkg.sv
// Shared constants and helpers for the gray-slotted TDM readout.
// Holds the slot-index and binary-to-gray functions used by the counter and the top.
package ro_pkg;

  localparam int RO_GRAY_W_MAX = 19;
  localparam int RO_IDX_W      = 5;

  // Gray code of a zero-extended binary count.
  function automatic logic [RO_GRAY_W_MAX-1:0] bin2gray(input logic [RO_GRAY_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Index of the lowest zero among the low n_ch bits of b; all-ones maps to n_ch-1.
  // This is the gray bit that toggles on the b -> b+1 step.
  function automatic logic [RO_IDX_W-1:0] ro_slot_idx(input logic [RO_GRAY_W_MAX-1:0] b,
                                                      input int n_ch);
    logic [RO_IDX_W-1:0] idx;
    logic                found;
    idx   = RO_IDX_W'(n_ch - 1);
    found = 1'b0;
    for (int i = 0; i < RO_GRAY_W_MAX; i++) begin
      if (!found && (i < n_ch) && !b[i]) begin
        idx   = RO_IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ro_tdm_readout_if.sv
// Output bus from the TDM readout to the off-chip serializer.
// Optional RO_CH_TAG_EN adds out_ch, the channel index of the slot just read.
interface ro_tdm_readout_if #(
  parameter int N_CH = 8
);
  localparam int CH_W = $clog2(N_CH);

  // out_valid qualifies out_* for exactly the one cycle it is high. There is no
  // ready: the serializer must take every valid cycle, since a slot never repeats.
  logic            out_valid;
  logic            out_eve;
  logic            out_pol_eve;
  logic            out_ovf;
`ifdef RO_CH_TAG_EN
  logic [CH_W-1:0] out_ch;
`endif

  modport master (
    output out_valid,
    output out_eve,
    output out_pol_eve,
`ifdef RO_CH_TAG_EN
    output out_ch,
`endif
    output out_ovf
  );

  modport slave (
    input out_valid,
    input out_eve,
    input out_pol_eve,
`ifdef RO_CH_TAG_EN
    input out_ch,
`endif
    input out_ovf
  );

endinterface

// File: rtl/ro_gray_count.sv
// Binary + gray counter with enable and asynchronous active-low reset.
// gray is registered alongside b so exactly one gray bit changes per advance.
module ro_gray_count
  import ro_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         en,
  output logic [N-1:0] b,
  output logic [N-1:0] gray
);

  logic [N-1:0]             b_next;
  logic [N-1:0]             gray_next;
  logic [RO_GRAY_W_MAX-1:0] b_next_ext;
  logic [RO_GRAY_W_MAX-1:0] gray_ext;

  always_comb begin
    b_next              = b + N'(1);
    b_next_ext          = '0;
    b_next_ext[N-1:0]   = b_next;
    gray_ext            = bin2gray(b_next_ext);
    gray_next           = gray_ext[N-1:0];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      b    <= '0;
      gray <= '0;
    end else if (en) begin
      b    <= b_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/ro_tdm_readout.sv
// N-channel gray-slotted time-division readout with per-channel sticky event latches.
// Define RO_CH_TAG_EN to also emit out_ch, the index of the channel read each slot.
module ro_tdm_readout
  import ro_pkg::*;
#(
  parameter int N_CH = 8
) (
  input  logic              clk_master,
  input  logic              rstb,
  input  logic              ro_en,
  input  logic [N_CH-1:0]   in_eve,
  input  logic [N_CH-1:0]   in_pol_eve,
  output logic [N_CH-1:0]   gray,
  ro_tdm_readout_if.master  ro_bus
);

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]          b;
  logic [N_CH-1:0]          lat_e;
  logic [N_CH-1:0]          lat_p;
  logic [N_CH-1:0]          ovf;
  logic [N_CH-1:0]          slot_oh;
  logic [N_CH-1:0]          ovf_hit;
  logic [RO_GRAY_W_MAX-1:0] b_ext;
  logic [RO_IDX_W-1:0]      slot_ext;
  logic [CH_W-1:0]          s;

  ro_gray_count #(.N(N_CH)) u_count (
    .clk  (clk_master),
    .rstb (rstb),
    .en   (ro_en),
    .b    (b),
    .gray (gray)
  );

  always_comb begin
    b_ext            = '0;
    b_ext[N_CH-1:0]  = b;
    slot_ext         = ro_slot_idx(b_ext, N_CH);
    s                = slot_ext[CH_W-1:0];
    slot_oh          = '0;
    slot_oh[s]       = 1'b1;
    // A second event arriving on a channel whose latch is already full is lost.
    ovf_hit          = (lat_e & in_eve) | (lat_p & in_pol_eve);
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      lat_e <= '0;
      lat_p <= '0;
      ovf   <= '0;
    end else if (ro_en) begin
      // The slot channel reports its same-edge input directly, so it is not retained.
      lat_e <= (lat_e | in_eve)     & ~slot_oh;
      lat_p <= (lat_p | in_pol_eve) & ~slot_oh;
      ovf   <= (ovf | ovf_hit)      & ~slot_oh;
    end else begin
      lat_e <= lat_e | in_eve;
      lat_p <= lat_p | in_pol_eve;
      ovf   <= ovf | ovf_hit;
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      ro_bus.out_valid   <= 1'b0;
      ro_bus.out_eve     <= 1'b0;
      ro_bus.out_pol_eve <= 1'b0;
      ro_bus.out_ovf     <= 1'b0;
    end else if (ro_en) begin
      ro_bus.out_valid   <= 1'b1;
      ro_bus.out_eve     <= lat_e[s] | in_eve[s];
      ro_bus.out_pol_eve <= lat_p[s] | in_pol_eve[s];
      ro_bus.out_ovf     <= ovf[s];
    end else begin
      ro_bus.out_valid   <= 1'b0;
      ro_bus.out_eve     <= 1'b0;
      ro_bus.out_pol_eve <= 1'b0;
      ro_bus.out_ovf     <= 1'b0;
    end
  end

`ifdef RO_CH_TAG_EN
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      ro_bus.out_ch <= '0;
    end else if (ro_en) begin
      ro_bus.out_ch <= s;
    end else begin
      ro_bus.out_ch <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_ro_tdm_readout.sv
// Directed self-checking bench for ro_tdm_readout at N_CH=4.
// Expected slot/gray sequences and event positions are hand-computed constants.
module tb_ro_tdm_readout;

  localparam int N = 4;

  logic         clk_master;
  logic         rstb;
  logic         ro_en;
  logic [N-1:0] in_eve;
  logic [N-1:0] in_pol_eve;
  logic [N-1:0] gray;

  int n_checks;
  int n_pass;

  ro_tdm_readout_if #(.N_CH(N)) ro_bus ();

  ro_tdm_readout #(.N_CH(N)) dut (
    .clk_master (clk_master),
    .rstb       (rstb),
    .ro_en      (ro_en),
    .in_eve     (in_eve),
    .in_pol_eve (in_pol_eve),
    .gray       (gray),
    .ro_bus     (ro_bus)
  );

  // Clock / reset
  initial clk_master = 1'b0;
  always #5 clk_master = ~clk_master;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Slot index and gray value after the edge taken at binary count b.
  logic [1:0] slot_tbl [16] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 3};
  logic [3:0] gray_tbl [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                4'b1011, 4'b1001, 4'b1000, 4'b0000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Driver: apply inputs at negedge, return 1 time unit after the next posedge.
  task automatic step(input logic en, input logic [N-1:0] e, input logic [N-1:0] p);
    @(negedge clk_master);
    ro_en      = en;
    in_eve     = e;
    in_pol_eve = p;
    @(posedge clk_master);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rstb       = 1'b0;
    ro_en      = 1'b0;
    in_eve     = '0;
    in_pol_eve = '0;
    repeat (2) @(posedge clk_master);
    #1;
    check("rst_gray",  32'(gray), 32'h0);
    check("rst_valid", 32'(ro_bus.out_valid), 32'h0);
    check("rst_eve",   32'(ro_bus.out_eve), 32'h0);
    check("rst_pol",   32'(ro_bus.out_pol_eve), 32'h0);
    check("rst_ovf",   32'(ro_bus.out_ovf), 32'h0);
    @(negedge clk_master);
    rstb = 1'b1;

    // Test 1: free run, no events
    for (int b = 0; b < 16; b++) begin
      step(1'b1, '0, '0);
      check("t1_gray",  32'(gray), 32'(gray_tbl[b]));
      check("t1_valid", 32'(ro_bus.out_valid), 32'h1);
      check("t1_eve",   32'(ro_bus.out_eve), 32'h0);
`ifdef RO_CH_TAG_EN
      check("t1_ch",    32'(ro_bus.out_ch), 32'(slot_tbl[b]));
`endif
    end

    // Test 2: ch2 event at b=4 is held until the ch2 slot at b=11
    for (int b = 0; b < 16; b++) begin
      step(1'b1, (b == 4) ? 4'b0100 : 4'b0000, '0);
      check("t2_eve", 32'(ro_bus.out_eve), (b == 11) ? 32'h1 : 32'h0);
      check("t2_ovf", 32'(ro_bus.out_ovf), 32'h0);
    end

    // Test 3: two ch3 events before its slot flag an overflow at b=7 only
    for (int b = 0; b < 16; b++) begin
      step(1'b1, (b == 1 || b == 3) ? 4'b1000 : 4'b0000, '0);
      check("t3_eve", 32'(ro_bus.out_eve), (b == 7) ? 32'h1 : 32'h0);
      check("t3_ovf", 32'(ro_bus.out_ovf), (b == 7) ? 32'h1 : 32'h0);
    end

    // Test 4: ch0 event on its own slot edge is reported, not retained
    for (int b = 0; b < 6; b++) begin
      step(1'b1, (b == 2) ? 4'b0001 : 4'b0000, '0);
      check("t4_eve", 32'(ro_bus.out_eve), (b == 2) ? 32'h1 : 32'h0);
    end

    // Test 5: freeze at b=6, pulse ch1 polarity event while frozen
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, (k == 2) ? 4'b0010 : 4'b0000);
      check("t5_gray",  32'(gray), 32'h5);
      check("t5_valid", 32'(ro_bus.out_valid), 32'h0);
      check("t5_pol",   32'(ro_bus.out_pol_eve), 32'h0);
    end
    for (int b = 6; b < 10; b++) begin
      // ch2 event at b=9 stays latched for the reset test below
      step(1'b1, (b == 9) ? 4'b0100 : 4'b0000, '0);
      check("t5_pol_re", 32'(ro_bus.out_pol_eve), (b == 9) ? 32'h1 : 32'h0);
      check("t5_eve_re", 32'(ro_bus.out_eve), 32'h0);
    end
    check("t5_valid_re", 32'(ro_bus.out_valid), 32'h1);

    // Test 6: async reset at b=10 with lat_e[2] pending
    ro_en      = 1'b0;
    in_eve     = '0;
    in_pol_eve = '0;
    #2;
    rstb = 1'b0;
    #1;
    check("t6_gray",  32'(gray), 32'h0);
    check("t6_valid", 32'(ro_bus.out_valid), 32'h0);
    check("t6_pol",   32'(ro_bus.out_pol_eve), 32'h0);
    @(negedge clk_master);
    rstb = 1'b1;
    for (int b = 0; b < 4; b++) begin
      step(1'b1, '0, '0);
      check("t6_gray_re", 32'(gray), 32'(gray_tbl[b]));
      check("t6_eve_re",  32'(ro_bus.out_eve), 32'h0);
`ifdef RO_CH_TAG_EN
      check("t6_ch",      32'(ro_bus.out_ch), 32'(slot_tbl[b]));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
